adder_arbiter: RTL and testbench

Round-robin arbiter and single-stage pipeline wrapper that shares one 32-bit carry-lookahead adder (propagate/generate/carry tree) between two requesters, the integer execute path (port 0) and the address-generation path (port 1). Each accepted request is an ADD/ADC/SUB/SBB operation. Its result and x86 flags (CF, OF, ZF) are registered and returned on a shared response channel tagged with the requester ID. The response channel supports back-pressure. While a response is held, no new request is accepted.

---
 rtl/adder_arbiter.sv | 124 ++++++++++++
 tb/tb_adder_arbiter.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_arbiter.sv
// Two requesters share one 32-bit prefix-tree adder. Round-robin arbitration feeds
// a single registered response slot with back-pressure and x86-style CF/OF/ZF flags.
module adder_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_sub,
  input  logic             req0_cin,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_sub,
  input  logic             req1_cin,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_sum,
  output logic             rsp_cf,
  output logic             rsp_of,
  output logic             rsp_zf
);
  localparam int LVLS = $clog2(WIDTH);

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             cin;
  } req_t;

  typedef struct packed {
    logic             id;
    logic [WIDTH-1:0] sum;
    logic             cf;
    logic             of;
    logic             zf;
  } rsp_t;

  req_t req0, req1, sel;
  rsp_t rsp_q, rsp_d;
  logic rsp_valid_q, last_grant;
  logic grant0, grant1, can_accept, accept;

  assign req0 = '{a: req0_a, b: req0_b, sub: req0_sub, cin: req0_cin};
  assign req1 = '{a: req1_a, b: req1_b, sub: req1_sub, cin: req1_cin};

  // On contention the port that did not win last time goes first.
  assign grant0     = req0_valid && (!req1_valid || last_grant);
  assign grant1     = req1_valid && (!req0_valid || !last_grant);
  assign can_accept = !rsp_valid_q || rsp_ready;
  assign req0_ready = grant0 && can_accept && !reset;
  assign req1_ready = grant1 && can_accept && !reset;
  assign accept     = req0_ready || req1_ready;
  assign sel        = grant1 ? req1 : req0;

  logic [WIDTH-1:0]           b_eff, sum;
  logic                       c_in, c_out;
  logic [LVLS:0][WIDTH-1:0]   g, p;

  // Kogge-Stone prefix tree; carry-in is folded into bit 0's generate so
  // g[LVLS][i] is the carry out of bit i.
  always_comb begin
    b_eff   = sel.sub ? ~sel.b : sel.b;
    c_in    = sel.cin ^ sel.sub;
    g       = '0;
    p       = '0;
    g[0]    = sel.a & b_eff;
    p[0]    = sel.a ^ b_eff;
    g[0][0] = g[0][0] | (p[0][0] & c_in);
    for (int k = 0; k < LVLS; k++) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (i >= (1 << k)) begin
          g[k+1][i] = g[k][i] | (p[k][i] & g[k][i-(1<<k)]);
          p[k+1][i] = p[k][i] & p[k][i-(1<<k)];
        end else begin
          g[k+1][i] = g[k][i];
          p[k+1][i] = p[k][i];
        end
      end
    end
    sum    = '0;
    sum[0] = p[0][0] ^ c_in;
    for (int i = 1; i < WIDTH; i++)
      sum[i] = p[0][i] ^ g[LVLS][i-1];
    c_out = g[LVLS][WIDTH-1];
  end

  always_comb begin
    rsp_d     = '0;
    rsp_d.id  = grant1;
    rsp_d.sum = sum;
    rsp_d.cf  = c_out ^ sel.sub;
    rsp_d.of  = (sel.a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != sel.a[WIDTH-1]);
    rsp_d.zf  = (sum == '0);
  end

  // Accept and drain in the same cycle simply overwrite the slot.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_valid_q <= 1'b0;
      rsp_q       <= '0;
      last_grant  <= 1'b1;
    end else if (accept) begin
      rsp_valid_q <= 1'b1;
      rsp_q       <= rsp_d;
      last_grant  <= grant1;
    end else if (rsp_ready) begin
      rsp_valid_q <= 1'b0;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_q.id;
  assign rsp_sum   = rsp_q.sum;
  assign rsp_cf    = rsp_q.cf;
  assign rsp_of    = rsp_q.of;
  assign rsp_zf    = rsp_q.zf;
endmodule

// File: tb/tb_adder_arbiter.sv
// Bench for adder_arbiter: directed vector table, contention/back-pressure/reset
// sequences, then random traffic against a transaction-level reference model.
module tb_adder_arbiter;
  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req0_ready, req0_sub, req0_cin;
  logic [31:0] req0_a, req0_b;
  logic        req1_valid, req1_ready, req1_sub, req1_cin;
  logic [31:0] req1_a, req1_b;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_cf, rsp_of, rsp_zf;
  logic [31:0] rsp_sum;

  int tests = 0;
  int fails = 0;

  adder_arbiter #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req0_sub(req0_sub), .req0_cin(req0_cin),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .req1_sub(req1_sub), .req1_cin(req1_cin),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_sum(rsp_sum),
    .rsp_cf(rsp_cf), .rsp_of(rsp_of), .rsp_zf(rsp_zf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a, b;
    logic        sub, cin;
    logic [31:0] sum;
    logic        cf, of, zf;
  } vec_t;

  typedef struct packed {
    logic [31:0] sum;
    logic        cf, of, zf;
  } res_t;

  // Reference arithmetic: plain 33-bit unsigned and 64-bit signed math.
  function automatic res_t ref_op(logic [31:0] a, logic [31:0] b, logic sub, logic cin);
    res_t r;
    logic [32:0] u;
    longint s;
    if (!sub) begin
      u = {1'b0, a} + {1'b0, b} + {32'd0, cin};
      s = longint'($signed(a)) + longint'($signed(b)) + longint'(cin);
    end else begin
      u = {1'b0, a} - {1'b0, b} - {32'd0, cin};
      s = longint'($signed(a)) - longint'($signed(b)) - longint'(cin);
    end
    r.sum = u[31:0];
    r.cf  = u[32];
    r.of  = (s > 64'sd2147483647) || (s < -64'sd2147483648);
    r.zf  = (u[31:0] == 32'd0);
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req0_valid = 0; req0_a = 0; req0_b = 0; req0_sub = 0; req0_cin = 0;
    req1_valid = 0; req1_a = 0; req1_b = 0; req1_sub = 0; req1_cin = 0;
  endtask

  // Called just after a rising edge; reset pulse stays clear of any edge.
  task automatic do_reset();
    idle_inputs();
    reset = 1;
    #2;
    reset = 0;
  endtask

  task automatic drive(input int port, input logic [31:0] a, input logic [31:0] b,
                       input logic sub, input logic cin);
    if (port == 0) begin
      req0_valid = 1; req0_a = a; req0_b = b; req0_sub = sub; req0_cin = cin;
    end else begin
      req1_valid = 1; req1_a = a; req1_b = b; req1_sub = sub; req1_cin = cin;
    end
  endtask

  task automatic check_rsp(input string tag, input logic id, input logic [31:0] sum,
                           input logic cf, input logic of, input logic zf);
    check({tag, ".valid"}, rsp_valid, 1);
    check({tag, ".id"},    rsp_id, id);
    check({tag, ".sum"},   rsp_sum, sum);
    check({tag, ".cf"},    rsp_cf, cf);
    check({tag, ".of"},    rsp_of, of);
    check({tag, ".zf"},    rsp_zf, zf);
  endtask

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'hffffffff;
      2:       return 32'h80000000;
      3:       return 32'h7fffffff;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t tbl[8];
    logic        held[2];
    logic [31:0] pa[2], pb[2];
    logic        psub[2], pcin[2];
    logic        m_valid, m_id, lg, can, e0, e1;
    int          w;
    res_t        m_res;

    tbl[0] = '{32'hffffffff, 32'h00000000, 1'b0, 1'b1, 32'h00000000, 1'b1, 1'b0, 1'b1};
    tbl[1] = '{32'h80000000, 32'h00000001, 1'b1, 1'b0, 32'h7fffffff, 1'b0, 1'b1, 1'b0};
    tbl[2] = '{32'h00000000, 32'h00000000, 1'b1, 1'b1, 32'hffffffff, 1'b1, 1'b0, 1'b0};
    tbl[3] = '{32'h7fffffff, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0};
    tbl[4] = '{32'h00000005, 32'h00000005, 1'b1, 1'b0, 32'h00000000, 1'b0, 1'b0, 1'b1};
    tbl[5] = '{32'h00000003, 32'h00000005, 1'b1, 1'b0, 32'hfffffffe, 1'b1, 1'b0, 1'b0};
    tbl[6] = '{32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1, 1'b1};
    tbl[7] = '{32'h12345678, 32'h00000001, 1'b0, 1'b1, 32'h1234567a, 1'b0, 1'b0, 1'b0};

    idle_inputs();
    rsp_ready = 1;
    reset = 1;
    #2;
    check("reset.rsp_valid", rsp_valid, 0);
    check("reset.rsp_id", rsp_id, 0);
    check("reset.rsp_sum", rsp_sum, 0);
    check("reset.flags", {rsp_cf, rsp_of, rsp_zf}, 0);
    tick();
    reset = 0;

    // Directed vectors, alternating ports, back-to-back.
    for (int i = 0; i < 8; i++) begin
      idle_inputs();
      drive(i % 2, tbl[i].a, tbl[i].b, tbl[i].sub, tbl[i].cin);
      #1;
      check($sformatf("vec%0d.ready", i), (i % 2 == 0) ? req0_ready : req1_ready, 1);
      tick();
      idle_inputs();
      check_rsp($sformatf("vec%0d", i), 1'(i % 2), tbl[i].sum, tbl[i].cf, tbl[i].of, tbl[i].zf);
    end
    tick();
    check("drain.rsp_valid", rsp_valid, 0);

    // Continuous contention: strict alternation, no bubbles.
    do_reset();
    rsp_ready = 1;
    drive(0, 32'ha47ba47b, 32'h5c915c91, 0, 0);
    drive(1, 32'hbcdabcda, 32'h79867986, 0, 0);
    for (int c = 0; c < 6; c++) begin
      #1;
      check($sformatf("rr%0d.ready0", c), req0_ready, (c % 2 == 0));
      check($sformatf("rr%0d.ready1", c), req1_ready, (c % 2 == 1));
      tick();
      check_rsp($sformatf("rr%0d", c), 1'(c % 2),
                (c % 2) ? 32'h36613660 : 32'h010d010c, 1, 0, 0);
    end
    idle_inputs();
    tick();
    check("rr.drain", rsp_valid, 0);

    // Back-pressure: port 0 wins, response held, then drain + port 1 accept.
    rsp_ready = 0;
    drive(0, 32'ha47ba47b, 32'h5c915c91, 0, 0);
    drive(1, 32'hbcdabcda, 32'h79867986, 0, 0);
    #1;
    check("bp.first_ready0", req0_ready, 1);
    tick();
    for (int c = 0; c < 3; c++) begin
      check($sformatf("bp%0d.readys", c), {req0_ready, req1_ready}, 0);
      check_rsp($sformatf("bp%0d", c), 0, 32'h010d010c, 1, 0, 0);
      tick();
    end
    rsp_ready = 1;
    #1;
    check("bp.release_ready1", req1_ready, 1);
    check("bp.release_ready0", req0_ready, 0);
    tick();
    check_rsp("bp.after", 1, 32'h36613660, 1, 0, 0);

    // Asynchronous reset while a stalled response is held.
    rsp_ready = 0;
    #2;
    reset = 1;
    #1;
    check("areset.rsp_valid", rsp_valid, 0);
    check("areset.rsp_sum", rsp_sum, 0);
    check("areset.id_flags", {rsp_id, rsp_cf, rsp_of, rsp_zf}, 0);
    check("areset.readys", {req0_ready, req1_ready}, 0);
    #2;
    reset = 0;
    rsp_ready = 1;
    #1;
    check("areset.first_grant0", req0_ready, 1);
    check("areset.first_grant1", req1_ready, 0);
    tick();
    check_rsp("areset.after", 0, 32'h010d010c, 1, 0, 0);

    // Random traffic against a transaction-level model.
    do_reset();
    m_valid = 0; m_id = 0; lg = 1; m_res = '0;
    for (int p = 0; p < 2; p++) begin
      held[p] = 0; pa[p] = 0; pb[p] = 0; psub[p] = 0; pcin[p] = 0;
    end
    for (int c = 0; c < 400; c++) begin
      for (int p = 0; p < 2; p++) begin
        if (!held[p] && $urandom_range(0, 3) != 0) begin
          held[p] = 1;
          pa[p] = rand_operand(); pb[p] = rand_operand();
          psub[p] = 1'($urandom_range(0, 1)); pcin[p] = 1'($urandom_range(0, 1));
        end
      end
      req0_valid = held[0]; req0_a = pa[0]; req0_b = pb[0]; req0_sub = psub[0]; req0_cin = pcin[0];
      req1_valid = held[1]; req1_a = pa[1]; req1_b = pb[1]; req1_sub = psub[1]; req1_cin = pcin[1];
      rsp_ready = ($urandom_range(0, 3) != 0);
      #1;
      can = !m_valid || rsp_ready;
      if (held[0] && held[1]) w = lg ? 0 : 1;
      else if (held[0])       w = 0;
      else if (held[1])       w = 1;
      else                    w = -1;
      e0 = can && (w == 0);
      e1 = can && (w == 1);
      check("rnd.ready0", req0_ready, e0);
      check("rnd.ready1", req1_ready, e1);
      check("rnd.rsp_valid", rsp_valid, m_valid);
      if (m_valid)
        check_rsp("rnd", m_id, m_res.sum, m_res.cf, m_res.of, m_res.zf);
      tick();
      if (e0 || e1) begin
        m_res   = ref_op(pa[w], pb[w], psub[w], pcin[w]);
        m_id    = 1'(w);
        m_valid = 1;
        lg      = 1'(w);
        held[w] = 0;
      end else if (m_valid && rsp_ready) begin
        m_valid = 0;
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
